// File: rtl/ir_pkg.sv
// Shared constants and types for the instruction register.
// The field positions are used only when IR_FIELD_DECODE_EN is defined.
package ir_pkg;

    localparam int IR_WIDTH = 16;
    localparam logic [IR_WIDTH-1:0] IR_RST_DEFAULT = 16'h0000;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef logic [IR_WIDTH-1:0] ir_word_t;

endpackage

// File: rtl/ir_dff_bit.sv
// Single-bit D flip-flop with a synchronous active-low reset to RST_BIT.
// It provides both true and complemented outputs.
module ir_dff_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RST_BIT;
        end else begin
            q <= d;
        end
    end

    // Derived from q so that qn can never disagree with it, even while q is X.
    assign qn = ~q;

endmodule

// File: rtl/instruction_register.sv
// Instruction register: a WIDTH-bit array of ir_dff_bit cells, reloaded on every clock edge.
// Define IR_FIELD_DECODE_EN to add the opcode/rd/rs/imm8 field outputs (WIDTH must be 16).
module instruction_register
    import ir_pkg::*;
#(
    parameter int                WIDTH   = IR_WIDTH,
    parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(IR_RST_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
`ifdef IR_FIELD_DECODE_EN
    output logic [WIDTH-1:0] qinv,
    output logic [3:0]       opcode,
    output logic [3:0]       rd,
    output logic [3:0]       rs,
    output logic [7:0]       imm8
`else
    output logic [WIDTH-1:0] qinv
`endif
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            ir_dff_bit #(
                .RST_BIT (RST_VAL[gi])
            ) u_bit (
                .clk (clk),
                .rst (rst),
                .d   (d[gi]),
                .q   (q[gi]),
                .qn  (qinv[gi])
            );
        end
    endgenerate

`ifdef IR_FIELD_DECODE_EN
    generate
        if (WIDTH != IR_WIDTH) begin : g_width_check
            $error("instruction_register: field decode requires WIDTH == 16");
        end
    endgenerate

    // The fields are plain slices of q, so they add no latency and follow RST_VAL.
    assign opcode = q[OPC_MSB:OPC_LSB];
    assign rd     = q[RD_MSB:RD_LSB];
    assign rs     = q[RS_MSB:RS_LSB];
    assign imm8   = q[IMM_MSB:IMM_LSB];
`endif

endmodule

// File: tb/tb_instruction_register.sv
// Scoreboard testbench for instruction_register: the stimulus pushes expected words,
// and a monitor pops them and compares after each rising edge.
module tb_instruction_register;

    localparam int W = 16;
    localparam logic [W-1:0] RST_WORD = 16'h0000;

    logic         clk;
    logic         rst;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qinv;
`ifdef IR_FIELD_DECODE_EN
    logic [3:0]   opcode;
    logic [3:0]   rd;
    logic [3:0]   rs;
    logic [7:0]   imm8;
`endif

    instruction_register dut (
        .clk    (clk),
        .rst    (rst),
        .d      (d),
        .q      (q),
`ifdef IR_FIELD_DECODE_EN
        .qinv   (qinv),
        .opcode (opcode),
        .rd     (rd),
        .rs     (rs),
        .imm8   (imm8)
`else
        .qinv   (qinv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_last;
    bit           have_last = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: after each edge, pop the word that edge should have captured.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q", q, e);
                chk("qinv", qinv, ~e);
`ifdef IR_FIELD_DECODE_EN
                chk("opcode", {12'h0, opcode}, {12'h0, e[15:12]});
                chk("rd", {12'h0, rd}, {12'h0, e[11:8]});
                chk("rs", {12'h0, rs}, {12'h0, e[7:4]});
                chk("imm8", {8'h0, imm8}, {8'h0, e[7:0]});
`endif
                $display("edge: q=%h qinv=%h expected=%h", q, qinv, e);
                exp_last = e;
                have_last = 1;
            end
        end
    end

    // One cycle: drive between edges, record what the next edge must load,
    // and confirm that changing the inputs has not disturbed q yet.
    task automatic step(input logic r, input logic [W-1:0] dv);
        @(negedge clk);
        rst = r;
        d   = dv;
        exp_q.push_back(r ? dv : RST_WORD);
        #1;
        if (have_last) chk("hold", q, exp_last);
    endtask

    // Pulse reset low between edges; the following edge must see rst high and load d.
    task automatic glitch_rst();
        @(negedge clk);
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        exp_q.push_back(d);
        #1;
        if (have_last) chk("glitch_hold", q, exp_last);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        d   = '0;

        step(1'b0, 16'h0010);
        step(1'b1, 16'h0010);
        step(1'b1, 16'h000A);
        step(1'b1, 16'h000A);
        step(1'b1, 16'h000A);
        glitch_rst();
        step(1'b0, 16'h000A);
        step(1'b1, 16'hFFFF);
        step(1'b1, 16'h5A5A);
        step(1'b1, 16'h0000);
        step(1'b1, 16'h3A7C);
        step(1'b0, 16'h3A7C);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), W'($urandom));
            if ($urandom_range(0, 19) == 0) glitch_rst();
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_register.md
Name: instruction_register

Overview:
- 16-bit (parameterisable) instruction register for the CPU datapath, between memory data bus and control unit.
- Captures the instruction word on the rising clock edge and presents it true (q) and complemented (qinv) to the decode logic.
- Built as an array of D flip-flop bit cells; every bit is cleared by a synchronous active-low reset.

Parameters:
- WIDTH, 16, instruction word width in bits (>=1).
- RST_VAL, 16'h0000 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous active-low reset; sampled only at rising clk edge.
- d  input  WIDTH  instruction word to capture.
- q  output  WIDTH  registered instruction word.
- qinv  output  WIDTH  bitwise complement of q.

Behaviour:
- One clock; reset is synchronous and active-low (rst, sampled on rising edge of clk).
- At each rising clk edge: rst==0 -> q <= RST_VAL; rst==1 -> q <= d. No enable; loads every cycle when not in reset.
- Reset has priority over d; d is ignored in a reset cycle.
- Reset values: q = RST_VAL (0x0000), qinv = ~RST_VAL (0xFFFF).
- qinv is combinational: qinv == ~q at all times, including reset and power-up. No separate qinv register, so no skew or mismatch is possible.
- Latency: d to q is 1 clock edge. Changes on d between edges have no effect on q.
- Changes on rst between edges have no effect. Reset is never asynchronous.
- Reset asserted mid-operation: q clears at the next rising edge; previous contents are lost.
- Before the first rising edge, q is unknown (X in simulation). The bench must apply reset before checking outputs.
- No X-propagation masking: X bits on d load as X.

Optional Feature:
- Macro IR_FIELD_DECODE_EN.
- Defined: adds registered-field outputs derived from q: opcode[3:0]=q[15:12], rd[3:0]=q[11:8], rs[3:0]=q[7:4], imm8[7:0]=q[7:0]. These are pure wiring from q, so they carry zero extra latency, and their reset values are the matching slices of RST_VAL. Requires WIDTH==16; elaboration error otherwise.
- Undefined: those ports do not exist; the port list is exactly clk, rst, d, q, qinv.

Decomposition:
- Shared package ir_pkg holds:
  - IR_WIDTH=16 and the default reset word.
  - Field position constants (OPC_MSB=15, OPC_LSB=12, RD_MSB=11, RD_LSB=8, RS_MSB=7, RS_LSB=4, IMM_MSB=7, IMM_LSB=0).
  - A packed typedef ir_word_t.
- Natural sub-module: ir_dff_bit, a single-bit D flip-flop with sync active-low reset to a per-bit reset value, with q and qn outputs. instruction_register generates WIDTH instances of it.

Test Plan:
- rst=0, d=0x0010, rising edge -> q=0x0000, qinv=0xFFFF (reset dominates d).
- rst=1, d=0x0010, rising edge -> q=0x0010, qinv=0xFFEF.
- rst=1, d changes to 0x000A between edges -> q holds 0x0010 until the next rising edge, then q=0x000A, qinv=0xFFF5. It stays so over further edges with d=0x000A.
- rst pulsed low then high between edges (no rising edge while low) -> q unchanged at 0x000A. Then rst=0 across a rising edge -> q=0x0000, qinv=0xFFFF on that edge.
- Back-to-back loads 0xFFFF, 0x5A5A, 0x0000 on consecutive edges -> q follows with 1-edge latency, and qinv==~q checked every cycle.
- IR_FIELD_DECODE_EN defined, load 0x3A7C -> opcode=0x3, rd=0xA, rs=0x7, imm8=0x7C. After reset, all fields are 0.
